// File: rtl/mem_arbiter_if.sv
// Request-side and RAM-side signals of the fetch/data memory arbiter.
// slave is the arbiter's view; master is the requester/RAM view.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  ramload, ramready,
    output iload, ihit, dload, dhit, err,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    output ramload, ramready,
    input  iload, ihit, dload, dhit, err,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-ported RAM.
// Data has priority; a bounded streak counter forces fetches through.
module mem_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter int          TIMEOUT      = 255,
  parameter logic [31:0] ERR_WORD     = 32'hBAD1BAD1
) (
  input logic         CLK,
  input logic         RST,
  mem_arbiter_if.slave bus
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM  = SW'(STARVE_LIMIT);
  localparam logic [7:0]    WLAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, IACC, DRD, DWR, DONE} state_t;

  state_t      state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [7:0]  wdog_q, wdog_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic        ihit_q, ihit_d;
  logic        dhit_q, dhit_d;
  logic        err_q, err_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic        dreq, starve, fin;

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    wdog_d   = wdog_q;
    addr_d   = addr_q;
    store_d  = store_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    ihit_d   = 1'b0;
    dhit_d   = 1'b0;
    err_d    = 1'b0;
    dreq     = bus.dREN | bus.dWEN;
    starve   = (STARVE_LIMIT != 0) && bus.iREN
               && (streak_q == SLIM);
    fin      = bus.ramready || (wdog_q == WLAST);
    unique case (state_q)
      IDLE: begin
        wdog_d = '0;
        if (dreq && !starve) begin
          state_d = bus.dWEN ? DWR : DRD;
          addr_d  = bus.daddr;
          if (bus.dWEN) store_d = bus.dstore;
          if (!bus.iREN)
            streak_d = '0;
          else if (streak_q != SLIM)
            streak_d = streak_q + 1'b1;
        end else if (bus.iREN) begin
          state_d  = IACC;
          addr_d   = bus.iaddr;
          streak_d = '0;
        end
      end
      IACC, DRD, DWR: begin
        if (fin) begin
          state_d = DONE;
          wdog_d  = '0;
          err_d   = !bus.ramready;
          // A timed-out read returns the error word instead of RAM data
          if (state_q == IACC) begin
            ihit_d  = 1'b1;
            iload_d = bus.ramready ? bus.ramload : ERR_WORD;
          end else begin
            dhit_d = 1'b1;
            if (state_q == DRD)
              dload_d = bus.ramready ? bus.ramload : ERR_WORD;
          end
        end else begin
          wdog_d = wdog_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ren_d = (state_d == IACC) || (state_d == DRD);
    wen_d = (state_d == DWR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      wdog_q   <= '0;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      err_q    <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      wdog_q   <= wdog_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
      ihit_q   <= ihit_d;
      dhit_q   <= dhit_d;
      err_q    <= err_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
    end
  end

  assign bus.ramREN   = ren_q;
  assign bus.ramWEN   = wen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected hits are queued when a
// request is raised and compared when the arbiter reports the hit.
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if bus();

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT(8),
    .ERR_WORD(32'hBAD1BAD1)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed {
    logic        d;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] gaddr[$];
  logic [31:0] mem [logic [31:0]];
  int          n_vec = 0;
  int          n_err = 0;
  int          ready_at = 1;
  int          acc = 0;
  int          excl_bad = 0;
  logic [31:0] last_dload = '0;

  function automatic logic [31:0] rd(logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction

  // RAM model, grant log and requester retirement on hit
  task automatic tick();
    @(negedge CLK);
    if ((bus.ihit && bus.dhit) || (bus.ramREN && bus.ramWEN))
      excl_bad++;
    if (bus.ramREN || bus.ramWEN) begin
      acc++;
      if (acc == 1) gaddr.push_back(bus.ramaddr);
      bus.ramready = (ready_at > 0) && (acc == ready_at);
      if (bus.ramready && bus.ramWEN)
        mem[bus.ramaddr] = bus.ramstore;
    end else begin
      acc = 0;
      bus.ramready = 1'b0;
    end
    bus.ramload = rd(bus.ramaddr);
    if (bus.ihit) bus.iREN = 1'b0;
    if (bus.dhit) begin
      bus.dREN = 1'b0;
      bus.dWEN = 1'b0;
    end
  endtask

  task automatic wait_hit(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.ihit || bus.dhit) && n < 40);
    if (n >= 40) begin
      n_vec++;
      n_err++;
      $display("FAIL hit_timeout: no hit after %0d cycles, required a hit", n);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    n_vec++;
    if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err,
         bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got ren=%b wen=%b ih=%b dh=%b err=%b addr=%h st=%h il=%h dl=%h, required all 0",
               bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err,
               bus.ramaddr, bus.ramstore, bus.iload, bus.dload);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_fetch();
    int n, ren;
    exp_t e, a;
    gaddr.delete();
    ready_at  = 1;
    bus.iaddr = 32'h40;
    bus.iREN  = 1'b1;
    sb.push_back('{1'b0, 1'b0, 32'h8C010004});
    n = 0;
    ren = 0;
    do begin
      tick();
      n++;
      if (bus.ramREN) ren++;
    end while (!(bus.ihit || bus.dhit) && n < 40);
    n_vec++;
    if (n !== 2) begin
      n_err++;
      $display("FAIL fetch_latency: got %0d, required 2", n);
    end
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    a = '{bus.dhit, bus.err, bus.dhit ? bus.dload : bus.iload};
    n_vec++;
    if (a !== e || !bus.ihit) begin
      n_err++;
      $display("FAIL fetch_hit: got %h ih=%b, required %h", a, bus.ihit, e);
    end
    tick();
    if (bus.ramREN) ren++;
    n_vec++;
    if (ren !== 1 || bus.ihit !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_strobes: got ren_cycles=%0d ihit=%b, required 1 and 0",
               ren, bus.ihit);
    end
    n_vec++;
    if (gaddr.size() != 1 || gaddr[0] !== 32'h40) begin
      n_err++;
      $display("FAIL fetch_addr: got %0d grants first=%h, required 1 at 00000040",
               gaddr.size(), gaddr.size() ? gaddr[0] : 32'h0);
    end
  endtask

  task automatic test_collision();
    int n;
    exp_t e, a;
    gaddr.delete();
    ready_at  = 1;
    bus.iaddr = 32'h44;
    bus.daddr = 32'h100;
    bus.iREN  = 1'b1;
    bus.dREN  = 1'b1;
    sb.push_back('{1'b1, 1'b0, rd(32'h100)});
    sb.push_back('{1'b0, 1'b0, rd(32'h44)});
    last_dload = rd(32'h100);
    for (int k = 0; k < 2; k++) begin
      wait_hit(n);
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      a = '{bus.dhit, bus.err, bus.dhit ? bus.dload : bus.iload};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL collision_hit%0d: got %h, required %h", k, a, e);
      end
    end
    tick();
    n_vec++;
    if (gaddr.size() != 2 || gaddr[0] !== 32'h100 || gaddr[1] !== 32'h44) begin
      n_err++;
      $display("FAIL collision_order: got %0d grants, required 00000100 then 00000044",
               gaddr.size());
    end
  endtask

  task automatic test_starvation();
    int n, issued;
    exp_t e, a;
    gaddr.delete();
    ready_at  = 1;
    bus.iaddr = 32'h80;
    bus.iREN  = 1'b1;
    bus.daddr = 32'h300;
    bus.dREN  = 1'b1;
    issued = 1;
    for (int k = 0; k < 4; k++)
      sb.push_back('{1'b1, 1'b0, rd(32'h300 + 32'(4 * k))});
    sb.push_back('{1'b0, 1'b0, rd(32'h80)});
    sb.push_back('{1'b1, 1'b0, rd(32'h310)});
    last_dload = rd(32'h310);
    for (int k = 0; k < 6; k++) begin
      wait_hit(n);
      n_vec++;
      if (n !== ((k == 0) ? 2 : 3)) begin
        n_err++;
        $display("FAIL starve_spacing%0d: got %0d cycles, required %0d",
                 k, n, (k == 0) ? 2 : 3);
      end
      e = (sb.size() != 0) ? sb.pop_front() : 'x;
      a = '{bus.dhit, bus.err, bus.dhit ? bus.dload : bus.iload};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL starve_order%0d: got %h, required %h", k, a, e);
      end
      if (bus.ihit) begin
        n_vec++;
        if (dut.streak_q !== '0) begin
          n_err++;
          $display("FAIL starve_streak: got %0d, required 0", dut.streak_q);
        end
      end
      if (bus.dhit && issued < 5) begin
        bus.daddr = 32'h300 + 32'(4 * issued);
        bus.dREN  = 1'b1;
        issued++;
      end
    end
    tick();
  endtask

  task automatic test_write();
    int n, wen, ren;
    exp_t e, a;
    ready_at   = 3;
    bus.daddr  = 32'h200;
    bus.dstore = 32'hDEADBEEF;
    bus.dREN   = 1'b1;
    bus.dWEN   = 1'b1;
    sb.push_back('{1'b1, 1'b0, last_dload});
    n = 0;
    wen = 0;
    ren = 0;
    do begin
      tick();
      n++;
      if (bus.ramWEN) wen++;
      if (bus.ramREN) ren++;
    end while (!(bus.ihit || bus.dhit) && n < 40);
    n_vec++;
    if (n !== 4 || wen !== 3 || ren !== 0) begin
      n_err++;
      $display("FAIL write_strobes: got hit_cycle=%0d wen=%0d ren=%0d, required 4 3 0",
               n, wen, ren);
    end
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    a = '{bus.dhit, bus.err, bus.dhit ? bus.dload : bus.iload};
    n_vec++;
    if (a !== e || bus.ramstore !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_hit: got %h store=%h, required %h store=deadbeef",
               a, bus.ramstore, e);
    end
    tick();
    n_vec++;
    if (bus.dhit !== 1'b0 || bus.ramWEN !== 1'b0) begin
      n_err++;
      $display("FAIL write_pulse: got dhit=%b wen=%b, required 0 0",
               bus.dhit, bus.ramWEN);
    end
  endtask

  task automatic test_timeout();
    int n;
    exp_t e, a;
    ready_at  = 0;
    bus.daddr = 32'h204;
    bus.dREN  = 1'b1;
    sb.push_back('{1'b1, 1'b1, 32'hBAD1BAD1});
    last_dload = 32'hBAD1BAD1;
    wait_hit(n);
    n_vec++;
    if (n !== 9) begin
      n_err++;
      $display("FAIL timeout_cycle: got %0d, required 9", n);
    end
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    a = '{bus.dhit, bus.err, bus.dhit ? bus.dload : bus.iload};
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL timeout_hit: got %h, required %h", a, e);
    end
    tick();
    tick();
    n_vec++;
    if ({bus.dhit, bus.err, bus.ramREN, bus.ramWEN} !== 4'b0) begin
      n_err++;
      $display("FAIL timeout_idle: got dh=%b err=%b ren=%b wen=%b, required 0",
               bus.dhit, bus.err, bus.ramREN, bus.ramWEN);
    end
  endtask

  task automatic test_reset_mid();
    int n, hits;
    exp_t e, a;
    ready_at  = 0;
    bus.daddr = 32'h208;
    bus.dREN  = 1'b1;
    hits = 0;
    tick();
    if (bus.dhit) hits++;
    tick();
    if (bus.dhit) hits++;
    RST = 1'b1;
    tick();
    if (bus.dhit) hits++;
    n_vec++;
    if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.err,
         bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== '0
        || hits != 0) begin
      n_err++;
      $display("FAIL reset_mid: got ren=%b dh=%b dl=%h addr=%h hits=%0d, required all 0",
               bus.ramREN, bus.dhit, bus.dload, bus.ramaddr, hits);
    end
    RST = 1'b0;
    ready_at  = 2;
    bus.daddr = 32'h200;
    bus.dREN  = 1'b1;
    sb.push_back('{1'b1, 1'b0, rd(32'h200)});
    wait_hit(n);
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    a = '{bus.dhit, bus.err, bus.dhit ? bus.dload : bus.iload};
    n_vec++;
    if (a !== e || n !== 3 || a.data !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL reset_recover: got %h at cycle %0d, required %h at 3",
               a, n, e);
    end
    tick();
  endtask

  task automatic test_exclusive();
    n_vec++;
    if (excl_bad !== 0) begin
      n_err++;
      $display("FAIL exclusive: got %0d overlap cycles, required 0", excl_bad);
    end
    n_vec++;
    if (sb.size() !== 0) begin
      n_err++;
      $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramready = 1'b0;
    mem[32'h40]  = 32'h8C010004;
    test_reset();
    test_fetch();
    test_collision();
    test_starvation();
    test_write();
    test_timeout();
    test_reset_mid();
    test_exclusive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1);
  end

endmodule
